// File: rtl/branch_redirect_unit.sv
// ID-stage control-flow resolution: computes next-PC targets and one-hot selects,
// holds each redirect until fetch accepts it, and issues the jal/jalr link write.
module branch_redirect_unit #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_instr,
    input  logic              id_opnd_ready,
    input  logic [31:0]       id_rs_val,
    input  logic [31:0]       id_rt_val,
    input  logic              fe_ready,
    output logic              beq,
    output logic              jmp,
    output logic              jr,
    output logic [31:0]       PCbranch,
    output logic [31:0]       PCjmp,
    output logic [31:0]       PCreg,
    output logic              redir_valid,
    output logic              flush_ifid,
    output logic              id_stall,
    output logic              link_we,
    output logic [4:0]        link_addr,
    output logic [31:0]       link_data,
    output logic [STAT_W-1:0] redir_count,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_OPND = 2'd1,
        REDIR     = 2'd2
    } state_t;

    state_t state, next_state;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic        is_beq, is_bne, is_j, is_jal, is_jr, is_jalr;
    logic        is_ctrl, need_opnd, taken;
    logic        resolve;
    logic [31:0] pc_plus4;
    logic [31:0] br_off;

    assign op    = id_instr[31:26];
    assign funct = id_instr[5:0];

    assign is_beq  = (op == 6'b000100);
    assign is_bne  = (op == 6'b000101);
    assign is_j    = (op == 6'b000010);
    assign is_jal  = (op == 6'b000011);
    assign is_jr   = (op == 6'b000000) && (funct == 6'b001000);
    assign is_jalr = (op == 6'b000000) && (funct == 6'b001001);

    assign is_ctrl   = is_beq | is_bne | is_j | is_jal | is_jr | is_jalr;
    assign need_opnd = id_valid & (is_beq | is_bne | is_jr | is_jalr);
    assign taken     = is_j | is_jal | is_jr | is_jalr
                     | (is_beq & (id_rs_val == id_rt_val))
                     | (is_bne & (id_rs_val != id_rt_val));

    assign pc_plus4 = id_pc + 32'd4;
    assign br_off   = {{14{id_instr[15]}}, id_instr[15:0], 2'b00};

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Redirect handshake: a redirect is consumed in any cycle where
    // redir_valid && fe_ready; until then selects and targets stay bit-stable
    // and ID is stalled. The wrong-path instruction in ID is ignored meanwhile.
    always_comb begin
        next_state = state;
        resolve    = 1'b0;
        id_stall   = 1'b0;
        flush_ifid = 1'b0;
        case (state)
            IDLE: begin
                if (id_valid && is_ctrl) begin
                    if (need_opnd && !id_opnd_ready) begin
                        id_stall   = 1'b1;
                        next_state = WAIT_OPND;
                    end else if (taken) begin
                        resolve    = 1'b1;
                        next_state = REDIR;
                    end
                end
            end
            WAIT_OPND: begin
                id_stall = !id_opnd_ready;
                if (!id_valid) begin
                    next_state = IDLE;
                end else if (id_opnd_ready) begin
                    if (taken) begin
                        resolve    = 1'b1;
                        next_state = REDIR;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            REDIR: begin
                id_stall = !fe_ready;
                if (fe_ready) begin
                    flush_ifid = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beq         <= 1'b0;
            jmp         <= 1'b0;
            jr          <= 1'b0;
            PCbranch    <= 32'd0;
            PCjmp       <= 32'd0;
            PCreg       <= 32'd0;
            redir_valid <= 1'b0;
            link_we     <= 1'b0;
            link_addr   <= 5'd0;
            link_data   <= 32'd0;
            redir_count <= '0;
        end else begin
            link_we <= 1'b0;
            if (resolve) begin
                beq         <= is_beq | is_bne;
                jmp         <= is_j | is_jal;
                jr          <= is_jr | is_jalr;
                PCbranch    <= pc_plus4 + br_off;
                PCjmp       <= {pc_plus4[31:28], id_instr[25:0], 2'b00};
                PCreg       <= id_rs_val;
                redir_valid <= 1'b1;
                if (is_jal || is_jalr) begin
                    link_we   <= 1'b1;
                    link_addr <= is_jal ? 5'd31 : id_instr[15:11];
                    link_data <= pc_plus4;
                end
            end else if (flush_ifid) begin
                beq         <= 1'b0;
                jmp         <= 1'b0;
                jr          <= 1'b0;
                PCbranch    <= 32'd0;
                PCjmp       <= 32'd0;
                PCreg       <= 32'd0;
                redir_valid <= 1'b0;
            end
            // Statistic saturates rather than wrapping so long runs stay meaningful.
            if (flush_ifid && (redir_count != {STAT_W{1'b1}})) begin
                redir_count <= redir_count + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Self-checking bench for branch_redirect_unit: vector table through a
// scoreboard queue, plus sequences for stalls, backpressure, reset, saturation.
module tb_branch_redirect_unit;

    localparam int SW = 4;
    localparam int EW = 137;

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic [31:0]   id_pc;
    logic [31:0]   id_instr;
    logic          id_opnd_ready;
    logic [31:0]   id_rs_val;
    logic [31:0]   id_rt_val;
    logic          fe_ready;
    logic          beq, jmp, jr;
    logic [31:0]   PCbranch, PCjmp, PCreg;
    logic          redir_valid, flush_ifid, id_stall, link_we;
    logic [4:0]    link_addr;
    logic [31:0]   link_data;
    logic [SW-1:0] redir_count;
    logic [1:0]    state_dbg;

    branch_redirect_unit #(.STAT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_instr(id_instr), .id_opnd_ready(id_opnd_ready),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .fe_ready(fe_ready),
        .beq(beq), .jmp(jmp), .jr(jr), .PCbranch(PCbranch), .PCjmp(PCjmp),
        .PCreg(PCreg), .redir_valid(redir_valid), .flush_ifid(flush_ifid),
        .id_stall(id_stall), .link_we(link_we), .link_addr(link_addr),
        .link_data(link_data), .redir_count(redir_count), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc, instr, rs, rt;
        logic        taken;
        logic [2:0]  sel;
        logic [31:0] pcb, pcj, pcr;
        logic        lwe;
        logic [4:0]  laddr;
        logic [31:0] ldata;
    } vec_t;

    vec_t            vq[$];
    logic [EW-1:0]   exp_q[$];
    int              checks = 0;
    int              errors = 0;
    int              exp_count = 0;

    function automatic logic [EW-1:0] pack(input logic [2:0] sel, input logic [31:0] pcb,
                                           input logic [31:0] pcj, input logic [31:0] pcr,
                                           input logic lwe, input logic [4:0] la,
                                           input logic [31:0] ld);
        return {sel, pcb, pcj, pcr, lwe, la, ld};
    endfunction

    // Link address/data only matter when a link write is expected.
    function automatic logic [EW-1:0] observed(input logic mask_link);
        return pack({beq, jmp, jr}, PCbranch, PCjmp, PCreg, link_we,
                    mask_link ? link_addr : 5'd0, mask_link ? link_data : 32'd0);
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkp(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic valid, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] rs, input logic [31:0] rt, input logic taken,
                           input logic [2:0] sel, input logic [31:0] pcb, input logic [31:0] pcj,
                           input logic [31:0] pcr, input logic lwe, input logic [4:0] la,
                           input logic [31:0] ld);
        vec_t v;
        v.valid = valid; v.pc = pc; v.instr = instr; v.rs = rs; v.rt = rt;
        v.taken = taken; v.sel = sel; v.pcb = pcb; v.pcj = pcj; v.pcr = pcr;
        v.lwe = lwe; v.laddr = la; v.ldata = ld;
        vq.push_back(v);
    endtask

    task automatic drive(input logic valid, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] rs, input logic [31:0] rt, input logic ready,
                         input logic fe);
        id_valid = valid; id_pc = pc; id_instr = instr; id_rs_val = rs;
        id_rt_val = rt; id_opnd_ready = ready; fe_ready = fe;
    endtask

    function automatic int sat_inc(input int c);
        return (c < (1 << SW) - 1) ? c + 1 : c;
    endfunction

    // Scoreboard pop: a redirect must appear exactly when one is expected.
    task automatic sample_redirect(input string name);
        logic [EW-1:0] e;
        chk1({name, "_redir_valid"}, redir_valid, exp_q.size() != 0);
        if (redir_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chkp({name, "_outputs"}, observed(e[37]), e);
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chkp("reset_outputs", observed(1'b1), '0);
        chk32("reset_flags", {25'd0, redir_valid, flush_ifid, id_stall, link_we,
                              beq, jmp, jr}, 32'd0);
        chk32("reset_count", 32'(redir_count), 32'd0);
        chk32("reset_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;

        add_vec(1, 32'h100, 32'h10220004, 5, 5, 1, 3'b100, 32'h114, 32'h00880010, 5, 0, 0, 0);
        add_vec(1, 32'h100, 32'h10220004, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 32'h100, 32'h14220004, 5, 6, 1, 3'b100, 32'h114, 32'h00880010, 5, 0, 0, 0);
        add_vec(1, 32'h100, 32'h14220004, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 32'h00400010, 32'h0C100040, 32'hA, 0, 1, 3'b010, 32'h00400114,
                32'h00400100, 32'hA, 1, 5'd31, 32'h00400014);
        add_vec(1, 32'h10000000, 32'h0BFFFFFF, 0, 0, 1, 3'b010, 32'h10000000,
                32'h1FFFFFFC, 0, 0, 0, 0);
        add_vec(1, 32'h2000, 32'h00600008, 32'h1234, 0, 1, 3'b001, 32'h2024,
                32'h01800020, 32'h1234, 0, 0, 0);
        add_vec(1, 32'h3000, 32'h00603809, 32'hCAFE0000, 0, 1, 3'b001, 32'h00011028,
                32'h0180E024, 32'hCAFE0000, 1, 5'd7, 32'h3004);
        add_vec(1, 32'hFFFFFFFC, 32'h10000000, 9, 9, 1, 3'b100, 32'h0, 32'h0, 9, 0, 0, 0);
        add_vec(1, 32'h400, 32'h00221820, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 32'h00400010, 32'h0C100040, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].valid, vq[i].pc, vq[i].instr, vq[i].rs, vq[i].rt, 1'b1, 1'b1);
            #1;
            chk1($sformatf("v%0d_stall", i), id_stall, 1'b0);
            if (vq[i].taken) begin
                exp_q.push_back(pack(vq[i].sel, vq[i].pcb, vq[i].pcj, vq[i].pcr,
                                     vq[i].lwe, vq[i].laddr, vq[i].ldata));
                exp_count = sat_inc(exp_count);
            end
            @(posedge clk); #1;
            id_valid = 1'b0;
            sample_redirect($sformatf("v%0d", i));
            if (vq[i].taken) begin
                chk1($sformatf("v%0d_flush", i), flush_ifid, 1'b1);
                @(posedge clk); #1;
                chk32($sformatf("v%0d_after", i), {28'd0, redir_valid, beq, jmp, jr}, 32'd0);
            end else begin
                chk1($sformatf("v%0d_flush", i), flush_ifid, 1'b0);
            end
            chk32($sformatf("v%0d_count", i), 32'(redir_count), 32'(exp_count));
        end

        // jr with operands missing for two cycles
        @(negedge clk);
        drive(1'b1, 32'h2000, 32'h00600008, 32'h0, 32'h0, 1'b0, 1'b1);
        #1 chk1("jr_stall_c1", id_stall, 1'b1);
        @(negedge clk);
        chk1("jr_stall_c2", id_stall, 1'b1);
        chk32("jr_wait_state", 32'(state_dbg), 32'd1);
        @(negedge clk);
        chk1("jr_stall_held_c3", id_stall, 1'b1);
        id_opnd_ready = 1'b1;
        id_rs_val = 32'h00001234;
        #1 chk1("jr_stall_released", id_stall, 1'b0);
        exp_q.push_back(pack(3'b001, 32'h2024, 32'h01800020, 32'h1234, 0, 0, 0));
        exp_count = sat_inc(exp_count);
        @(posedge clk); #1;
        id_valid = 1'b0;
        sample_redirect("jr_wait");
        @(posedge clk); #1;
        chk32("jr_wait_count", 32'(redir_count), 32'(exp_count));

        // jal held under fetch backpressure
        @(negedge clk);
        drive(1'b1, 32'h00400010, 32'h0C100040, 32'hA, 32'h0, 1'b1, 1'b0);
        exp_q.push_back(pack(3'b010, 32'h00400114, 32'h00400100, 32'hA, 1, 5'd31, 32'h00400014));
        @(posedge clk); #1;
        id_valid = 1'b0;
        sample_redirect("bp_first");
        chk1("bp_stall_0", id_stall, 1'b1);
        chk1("bp_flush_0", flush_ifid, 1'b0);
        for (int k = 1; k < 3; k++) begin
            @(posedge clk); #1;
            chk1($sformatf("bp_valid_%0d", k), redir_valid, 1'b1);
            chkp($sformatf("bp_hold_%0d", k), observed(1'b0),
                 pack(3'b010, 32'h00400114, 32'h00400100, 32'hA, 0, 0, 0));
            chk1($sformatf("bp_stall_%0d", k), id_stall, 1'b1);
            chk1($sformatf("bp_flush_%0d", k), flush_ifid, 1'b0);
            chk32($sformatf("bp_count_%0d", k), 32'(redir_count), 32'(exp_count));
        end
        @(negedge clk);
        fe_ready = 1'b1;
        #1;
        chk1("bp_accept_flush", flush_ifid, 1'b1);
        chk1("bp_accept_stall", id_stall, 1'b0);
        exp_count = sat_inc(exp_count);
        @(posedge clk); #1;
        chk1("bp_after_valid", redir_valid, 1'b0);
        chk32("bp_count", 32'(redir_count), 32'(exp_count));

        // asynchronous reset in the middle of a held redirect
        @(negedge clk);
        drive(1'b1, 32'h10000000, 32'h0BFFFFFF, 32'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk); #1;
        id_valid = 1'b0;
        chk1("rst_pre_valid", redir_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chkp("rst_mid_outputs", observed(1'b1), '0);
        chk32("rst_mid_flags", {28'd0, redir_valid, flush_ifid, id_stall, link_we}, 32'd0);
        chk32("rst_mid_count", 32'(redir_count), 32'd0);
        chk32("rst_mid_state", 32'(state_dbg), 32'd0);
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        fe_ready = 1'b1;

        // counter saturation
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            drive(1'b1, 32'h10000000, 32'h0BFFFFFF, 32'h0, 32'h0, 1'b1, 1'b1);
            exp_count = sat_inc(exp_count);
            @(posedge clk); #1;
            id_valid = 1'b0;
            @(posedge clk); #1;
            if (n == 14 || n == 15 || n == 17)
                chk32($sformatf("sat_count_%0d", n), 32'(redir_count), 32'(exp_count));
        end
        chk32("sat_final", 32'(redir_count), 32'd15);
        chk32("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
